// File: rtl/pong_pkg.sv
// Shared PONG geometry, coordinate width and ball FSM state encodings.
// Used by the ball datapath, its bus interface and anything that draws the ball.
package pong_pkg;

  localparam int P_W        = 10;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_H   = 64;
  localparam int PADDLE_W   = 8;
  localparam int PADDLE_X_L = 16;
  localparam int PADDLE_X_R = 616;

  // Serve position and the columns/rows where the ball is tested against walls and paddles.
  localparam logic [P_W-1:0] CX      = P_W'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [P_W-1:0] CY      = P_W'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [P_W-1:0] X_L_HIT = P_W'(PADDLE_X_L + PADDLE_W);
  localparam logic [P_W-1:0] X_R_HIT = P_W'(PADDLE_X_R - BALL_SIZE);
  localparam logic [P_W-1:0] X_MAX   = P_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [P_W-1:0] Y_MAX   = P_W'(V_ACTIVE - BALL_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } ball_state_e;

  // Vertical overlap of ball and paddle; one extra bit so the sums cannot wrap.
  function automatic logic overlap(input logic [P_W-1:0] y, input logic [P_W-1:0] py);
    logic [P_W:0] ball_bot;
    logic [P_W:0] pad_bot;
    ball_bot = {1'b0, y} + (P_W+1)'(BALL_SIZE);
    pad_bot  = {1'b0, py} + (P_W+1)'(PADDLE_H);
    return (ball_bot > {1'b0, py}) && ({1'b0, y} < pad_bot);
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Bus between game control (master) and the ball mover (slave), plus the ball FSM debug state.
// serve is a bare 1-clk request with no ready: the slave acts on it only in IDLE and drops it otherwise.
interface ball_motion_if;
  import pong_pkg::*;

  logic           clk_ball;
  logic           serve;
  logic           serve_dir_right;
  logic [P_W-1:0] paddle_l_y;
  logic [P_W-1:0] paddle_r_y;
  logic [P_W-1:0] ball_x;
  logic [P_W-1:0] ball_y;
  logic           ball_active;
  logic           hit;
  logic           miss_l;
  logic           miss_r;
  ball_state_e    dbg_state;

  modport master (
    output clk_ball, serve, serve_dir_right, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, ball_active, hit, miss_l, miss_r, dbg_state
  );

  modport slave (
    input  clk_ball, serve, serve_dir_right, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, ball_active, hit, miss_l, miss_r, dbg_state
  );

endinterface

// File: rtl/tick_edge_sync.sv
// Synchronises a slow square-wave tick into clk and emits a 1-clk pulse per rising edge.
// The pulse is registered, so a consumer acts on the third clk edge after the tick is first sampled high.
module tick_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_in,
  output logic step
);

  logic s1_q, s2_q, s3_q, step_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      s1_q   <= tick_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      step_q <= s2_q & ~s3_q;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/ball_motion.sv
// PONG ball mover: one pixel per clk_ball tick, wall/paddle bounces, miss reporting.
// FSM IDLE -> RUN -> MISS -> IDLE; ball parked at centre outside RUN.
module ball_motion
  import pong_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  ball_motion_if.slave bus
);

  logic           step;
  ball_state_e    state_q, state_d;
  logic [P_W-1:0] x_q, x_d, y_q, y_d;
  logic           dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic           hit_q, hit_d, miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic           active_q;
  logic           ovl_l, ovl_r;

  tick_edge_sync u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_in (bus.clk_ball),
    .step    (step)
  );

  assign ovl_l = overlap(y_q, bus.paddle_l_y);
  assign ovl_r = overlap(y_q, bus.paddle_r_y);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    hit_d    = 1'b0;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = CX;
        y_d = CY;
        if (bus.serve) begin
          state_d  = S_RUN;
          dx_neg_d = ~bus.serve_dir_right;
          dy_neg_d = 1'b0;
        end
      end
      S_RUN: begin
        if (step) begin
          // Axes are independent: both can bounce on the same step.
          if (dy_neg_q && y_q == '0) begin
            dy_neg_d = 1'b0;
            y_d      = P_W'(1);
          end else if (!dy_neg_q && y_q == Y_MAX) begin
            dy_neg_d = 1'b1;
            y_d      = Y_MAX - P_W'(1);
          end else begin
            y_d = dy_neg_q ? y_q - P_W'(1) : y_q + P_W'(1);
          end
          if (dx_neg_q && x_q == X_L_HIT && ovl_l) begin
            dx_neg_d = 1'b0;
            x_d      = X_L_HIT + P_W'(1);
            hit_d    = 1'b1;
          end else if (dx_neg_q && x_q == '0) begin
            state_d  = S_MISS;
            miss_l_d = 1'b1;
          end else if (!dx_neg_q && x_q == X_R_HIT && ovl_r) begin
            dx_neg_d = 1'b1;
            x_d      = X_R_HIT - P_W'(1);
            hit_d    = 1'b1;
          end else if (!dx_neg_q && x_q == X_MAX) begin
            state_d  = S_MISS;
            miss_r_d = 1'b1;
          end else begin
            x_d = dx_neg_q ? x_q - P_W'(1) : x_q + P_W'(1);
          end
          if (state_d == S_MISS) begin
            x_d = CX;
            y_d = CY;
          end
        end
      end
      S_MISS: begin
        state_d = S_IDLE;
        x_d     = CX;
        y_d     = CY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= CX;
      y_q      <= CY;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      active_q <= (state_d == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.ball_active = active_q;
  assign bus.hit         = hit_q;
  assign bus.miss_l      = miss_l_q;
  assign bus.miss_r      = miss_r_q;
  assign bus.dbg_state   = state_q;

endmodule
